soc_bus_decoder: RTL



---
 rtl/soc_bus_decoder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/soc_bus_decoder.sv
// Memory-bus decoder between the core master port and NSLV memory-mapped slaves.
// One outstanding transaction; unmapped accesses and silent slaves get an error response.
module soc_bus_decoder #(
    parameter int unsigned          XLEN      = 32,
    parameter int unsigned          NSLV      = 3,
    parameter logic [NSLV*XLEN-1:0] SLV_BASE  = {32'h0C00_0000, 32'h1000_0000, 32'h8000_0000},
    parameter logic [NSLV*XLEN-1:0] SLV_RANGE = {32'h1000, 32'h1000, 32'h1000},
    parameter int unsigned          TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 m_req,
    input  logic                 m_we,
    input  logic [XLEN-1:0]      m_addr,
    input  logic [XLEN-1:0]      m_wdata,
    input  logic [XLEN/8-1:0]    m_be,
    output logic                 m_gnt,
    output logic                 m_rvalid,
    output logic [XLEN-1:0]      m_rdata,
    output logic                 m_err,
    output logic [NSLV-1:0]      s_req,
    output logic                 s_we,
    output logic [XLEN-1:0]      s_addr,
    output logic [XLEN-1:0]      s_wdata,
    output logic [XLEN/8-1:0]    s_be,
    input  logic [NSLV-1:0]      s_gnt,
    input  logic [NSLV-1:0]      s_rvalid,
    input  logic [NSLV*XLEN-1:0] s_rdata
);
    localparam int unsigned SW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW:0] TO_CMP = (CW + 1)'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, ERR} state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic            hit;
    logic [SW-1:0]   sel;
    logic [SW-1:0]   sel_eff;
    logic [NSLV-1:0] sel_1h;
    logic [XLEN-1:0] base_sel;
    logic [XLEN-1:0] rdata_sel;
    logic            gnt_sel;
    logic            rvalid_sel;

    // Descending scan so the lowest matching index wins; the extra bit keeps
    // BASE+RANGE past 2^XLEN from wrapping.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ({1'b0, m_addr} >= {1'b0, SLV_BASE[i*XLEN +: XLEN]} &&
                ({1'b0, m_addr} - {1'b0, SLV_BASE[i*XLEN +: XLEN]}) <
                {1'b0, SLV_RANGE[i*XLEN +: XLEN]}) begin
                hit = 1'b1;
                sel = SW'(i);
            end
        end
    end

    // Fresh decode while idle, latched selection once the transaction is underway.
    assign sel_eff = (state_q == IDLE) ? sel : sel_q;

    always_comb begin
        sel_1h     = '0;
        base_sel   = '0;
        rdata_sel  = '0;
        gnt_sel    = 1'b0;
        rvalid_sel = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_eff == SW'(i)) begin
                sel_1h[i]  = 1'b1;
                base_sel   = SLV_BASE[i*XLEN +: XLEN];
                rdata_sel  = s_rdata[i*XLEN +: XLEN];
                gnt_sel    = s_gnt[i];
                rvalid_sel = s_rvalid[i];
            end
        end
    end

    assign s_addr  = m_addr - base_sel;
    assign s_we    = m_we;
    assign s_wdata = m_wdata;
    assign s_be    = m_be;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        s_req    = '0;
        m_gnt    = 1'b0;
        m_rvalid = 1'b0;
        m_err    = 1'b0;
        m_rdata  = '0;
        unique case (state_q)
            IDLE: begin
                if (m_req) begin
                    if (hit) begin
                        s_req = sel_1h;
                        sel_d = sel;
                        cnt_d = '0;
                        if (gnt_sel) begin
                            m_gnt   = 1'b1;
                            state_d = WAIT;
                        end else begin
                            state_d = REQ;
                        end
                    end else begin
                        m_gnt   = 1'b1;
                        state_d = ERR;
                    end
                end
            end
            REQ: begin
                s_req = sel_1h;
                cnt_d = '0;
                if (gnt_sel) begin
                    m_gnt   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A response in the final allowed cycle beats the timeout.
                if (rvalid_sel) begin
                    m_rvalid = 1'b1;
                    m_rdata  = rdata_sel;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else if (({1'b0, cnt_q} + 1'b1) == TO_CMP) begin
                    cnt_d   = '0;
                    state_d = ERR;
                end
            end
            ERR: begin
                m_rvalid = 1'b1;
                m_err    = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
